// File: rtl/interconnect_pkg.sv
// Shared AXI encodings and the read-responder state type.
package interconnect_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
    localparam logic [1:0] AXI_BURST_RSVD  = 2'b11;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} axi_rd_resp_state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-beat address for FIXED/INCR/WRAP bursts; wrap window is
// (len+1)<<size bytes aligned down from the current address.
module axi_burst_addr_gen
    import interconnect_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [2:0]            size,
    input  logic [7:0]            len,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] stepped;
    logic [ADDR_WIDTH-1:0] wrap_mask;
    logic [ADDR_WIDTH-1:0] wrap_base;

    // Step by 2^size; WRAP keeps the low bits inside the window, so a
    // burst starting at the window base simply counts up like INCR.
    always_comb begin
        step      = ADDR_WIDTH'(1) << size;
        stepped   = addr + step;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        wrap_base = addr & ~wrap_mask;
        next_addr = stepped;
        case (burst)
            AXI_BURST_FIXED: next_addr = addr;
            AXI_BURST_WRAP:  next_addr = wrap_base | (stepped & wrap_mask);
            default:         next_addr = stepped;
        endcase
    end

endmodule

// File: rtl/axi_mem_read_responder.sv
// AXI4 read-only subordinate in front of a 1-cycle-latency SRAM.
// One burst at a time; 2-entry R buffer whose slot for the read in flight
// is filled straight from mem_rdata_i on the landing cycle.
module axi_mem_read_responder
    import interconnect_pkg::*;
#(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 64,
    parameter int                        AXI_ID_WIDTH   = 4,
    parameter int                        MEM_DEPTH      = 4096,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    localparam int                       MEM_ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      s_ar_valid_i,
    output logic                      s_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] s_ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]   s_ar_id_i,
    input  logic [7:0]                s_ar_len_i,
    input  logic [2:0]                s_ar_size_i,
    input  logic [1:0]                s_ar_burst_i,
    output logic                      s_r_valid_o,
    input  logic                      s_r_ready_i,
    output logic [AXI_DATA_WIDTH-1:0] s_r_data_o,
    output logic [AXI_ID_WIDTH-1:0]   s_r_id_o,
    output logic [1:0]                s_r_resp_o,
    output logic                      s_r_last_o,
    output logic                      mem_req_o,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int BPW     = AXI_DATA_WIDTH / 8;
    localparam int OFF_LSB = $clog2(BPW);
    localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES = (AXI_ADDR_WIDTH+1)'(MEM_DEPTH * BPW);

    // live: data not yet captured, take it from mem_rdata_i this cycle
    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [1:0]                resp;
        logic                      last;
        logic                      live;
    } rbuf_ent_t;

    axi_rd_resp_state_e        state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q, next_addr, off;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [7:0]                len_q, beat_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic                      berr_q, beat_err, issue, pop;
    logic [1:0]                cnt_q, cnt_d, cnt_pop;
    rbuf_ent_t [1:0]           ent_q, ent_d, res;
    rbuf_ent_t                 push_ent;

    axi_burst_addr_gen #(.ADDR_WIDTH(AXI_ADDR_WIDTH)) u_addr_gen (
        .addr      (addr_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Map the beat address to an SRAM word and flag beats outside the window.
    always_comb begin
        off        = addr_q - BASE_ADDR;
        beat_err   = berr_q || (addr_q < BASE_ADDR) || ({1'b0, off} >= MEM_BYTES);
        mem_addr_o = off[OFF_LSB +: MEM_ADDR_WIDTH];
    end

    // Next state; a beat is issued whenever buffer + in-flight has room.
    always_comb begin
        state_d      = state_q;
        s_ar_ready_o = 1'b0;
        issue        = 1'b0;
        case (state_q)
            IDLE: begin
                s_ar_ready_o = 1'b1;
                if (s_ar_valid_i) state_d = ISSUE;
            end
            ISSUE: begin
                issue = (cnt_q < 2'd2);
                if (issue && (beat_q == len_q)) state_d = DRAIN;
            end
            DRAIN: begin
                // leave on the final R handshake so the next AR fits right after
                if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && s_r_ready_i)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        mem_req_o = issue && !beat_err;
    end

    // R buffer: resolve landing data, pop the head, append the new beat.
    always_comb begin
        res = ent_q;
        for (int i = 0; i < 2; i++) begin
            if (ent_q[i].live) begin
                res[i].data = mem_rdata_i;
                res[i].live = 1'b0;
            end
        end
        pop           = (cnt_q != 2'd0) && s_r_ready_i;
        cnt_pop       = cnt_q - {1'b0, pop};
        push_ent.data = '0;
        push_ent.resp = beat_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        push_ent.last = (beat_q == len_q);
        push_ent.live = !beat_err;
        ent_d = res;
        if (pop) begin
            ent_d[0] = res[1];
            ent_d[1] = '0;
        end
        if (issue) ent_d[cnt_pop[0]] = push_ent;
        cnt_d = cnt_pop + {1'b0, issue};
    end

    assign s_r_valid_o = (cnt_q != 2'd0);
    assign s_r_data_o  = res[0].data;
    assign s_r_resp_o  = res[0].resp;
    assign s_r_last_o  = res[0].last;
    assign s_r_id_o    = id_q;

    // State, burst context and buffer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            addr_q  <= '0;
            id_q    <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            berr_q  <= 1'b0;
            beat_q  <= '0;
            ent_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ent_q   <= ent_d;
            cnt_q   <= cnt_d;
            if ((state_q == IDLE) && s_ar_valid_i) begin
                addr_q  <= s_ar_addr_i;
                id_q    <= s_ar_id_i;
                len_q   <= s_ar_len_i;
                size_q  <= s_ar_size_i;
                burst_q <= s_ar_burst_i;
                beat_q  <= '0;
                berr_q  <= (s_ar_size_i > 3'(OFF_LSB)) || (s_ar_burst_i == AXI_BURST_RSVD) ||
                           ((s_ar_burst_i == AXI_BURST_WRAP) && !wrap_len_ok(s_ar_len_i));
            end else if (issue) begin
                addr_q <= next_addr;
                beat_q <= beat_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_axi_mem_read_responder.sv
// Randomized bench with a queue-based burst model and one R-channel checker.
module tb_axi_mem_read_responder;

    localparam int          AW    = 32;
    localparam int          DW    = 64;
    localparam int          IW    = 4;
    localparam int          DEPTH = 4096;
    localparam int          MAW   = 12;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic           clk, rst_n;
    logic           s_ar_valid, s_ar_ready;
    logic [AW-1:0]  s_ar_addr;
    logic [IW-1:0]  s_ar_id;
    logic [7:0]     s_ar_len;
    logic [2:0]     s_ar_size;
    logic [1:0]     s_ar_burst;
    logic           s_r_valid, s_r_ready, s_r_last;
    logic [DW-1:0]  s_r_data;
    logic [IW-1:0]  s_r_id;
    logic [1:0]     s_r_resp;
    logic           mem_req;
    logic [MAW-1:0] mem_addr;
    logic [DW-1:0]  mem_rdata;

    axi_mem_read_responder #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .AXI_ID_WIDTH   (IW),
        .MEM_DEPTH      (DEPTH),
        .BASE_ADDR      (BASE)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .s_ar_valid_i (s_ar_valid),
        .s_ar_ready_o (s_ar_ready),
        .s_ar_addr_i  (s_ar_addr),
        .s_ar_id_i    (s_ar_id),
        .s_ar_len_i   (s_ar_len),
        .s_ar_size_i  (s_ar_size),
        .s_ar_burst_i (s_ar_burst),
        .s_r_valid_o  (s_r_valid),
        .s_r_ready_i  (s_r_ready),
        .s_r_data_o   (s_r_data),
        .s_r_id_o     (s_r_id),
        .s_r_resp_o   (s_r_resp),
        .s_r_last_o   (s_r_last),
        .mem_req_o    (mem_req),
        .mem_addr_o   (mem_addr),
        .mem_rdata_i  (mem_rdata)
    );

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    beat_t  exp_q[$];
    int     n_vec = 0, n_err = 0;
    int     req_seen = 0, req_exp = 0, n_beats = 0;
    int     rmode = 0, rpat = 0;
    longint cyc = 0, hs_cyc = 0, first_v_cyc = 0, last_r_cyc = 0;
    bit     lat_arm = 0;
    int     w_incr[4] = '{8, 9, 10, 11};
    int     w_wrap[4] = '{11, 8, 9, 10};

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SRAM contents are a fixed function of the word index.
    function automatic logic [63:0] pat(input int unsigned w);
        return ({32'(w), 32'(w)} * 64'h9E37_79B9_7F4A_7C15) ^ 64'hDEAD_0000_BEEF_0000;
    endfunction

    // SRAM: 1-cycle latency; garbage on cycles without a request.
    initial forever begin
        @(posedge clk);
        if (mem_req) mem_rdata <= pat(32'(mem_addr));
        else         mem_rdata <= {$urandom, $urandom};
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && mem_req) req_seen++;
    end

    // R ready: 0 always-on, 1 pattern 1,0,0,1, 2 random.
    initial begin
        s_r_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       s_r_ready = 1'b1;
                1: begin s_r_ready = ((rpat % 4) == 0) || ((rpat % 4) == 3); rpat++; end
                default: s_r_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", nm, got, exp);
        end
    endtask

    // Closed-form address of beat i.
    function automatic logic [31:0] beat_addr(input logic [31:0] addr, input int len,
                                              input int size, input int burst, input int i);
        longint unsigned inc, bnd, base, a;
        a   = 64'(addr);
        inc = 64'd1 << size;
        if (burst == 0) return addr;
        if (burst == 2) begin
            bnd  = 64'(len + 1) * inc;
            base = (a / bnd) * bnd;
            return 32'(base + ((a - base) + 64'(i) * inc) % bnd);
        end
        return 32'(a + 64'(i) * inc);
    endfunction

    task automatic model_push(input logic [31:0] addr, input logic [3:0] id, input int len,
                              input int size, input int burst);
        bit          err_all, err;
        logic [31:0] a;
        beat_t       b;
        err_all = (size > 3) || (burst == 3) ||
                  (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        for (int i = 0; i <= len; i++) begin
            a      = beat_addr(addr, len, size, burst, i);
            err    = err_all || (a < BASE) || ((a - BASE) >= 32'(DEPTH * 8));
            b.data = err ? 64'd0 : pat((a - BASE) >> 3);
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == len);
            b.id   = id;
            exp_q.push_back(b);
            if (!err) req_exp++;
        end
    endtask

    // Single R-side checker: order, content, hold-while-stalled, AR busy.
    initial begin
        logic [71:0] hold;
        bit          stall_q;
        beat_t       e;
        stall_q = 0;
        hold    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) stall_q = 0;
            else begin
                if (stall_q)
                    chk("r_hold_stable", {s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id}, hold);
                if (exp_q.size() != 0) chk("ar_ready_while_busy", s_ar_ready, 0);
                if (lat_arm && s_r_valid) begin
                    first_v_cyc = cyc;
                    lat_arm     = 0;
                end
                if (s_r_valid && s_r_ready) begin
                    n_beats++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL r_extra_beat: actual beat data %0h required none", s_r_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("r_data", s_r_data, e.data);
                        chk("r_resp", s_r_resp, e.resp);
                        chk("r_last", s_r_last, e.last);
                        chk("r_id", s_r_id, e.id);
                    end
                    if (s_r_last) last_r_cyc = cyc;
                end
                stall_q = s_r_valid && !s_r_ready;
                hold    = {s_r_valid, s_r_data, s_r_resp, s_r_last, s_r_id};
            end
        end
    end

    // Present an AR and hold it until accepted; returns just after the handshake edge.
    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id, input int len,
                           input int size, input int burst, input bit chk_b2b);
        int t;
        s_ar_addr  = addr;
        s_ar_id    = id;
        s_ar_len   = 8'(len);
        s_ar_size  = 3'(size);
        s_ar_burst = 2'(burst);
        s_ar_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!s_ar_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!s_ar_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ar_accept_timeout: actual ready 0 required 1");
            @(posedge clk);
            #1 s_ar_valid = 1'b0;
            return;
        end
        hs_cyc = cyc;
        if (chk_b2b) chk("b2b_accept_cycle", 128'(hs_cyc), 128'(last_r_cyc + 1));
        @(posedge clk);
        model_push(addr, id, len, size, burst);
        lat_arm = 1;
        #1;
        s_ar_valid = 1'b0;
        s_ar_addr  = $urandom;
        s_ar_id    = 4'($urandom);
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL burst_timeout: actual %0d beats outstanding required 0", exp_q.size());
            exp_q.delete();
        end
        chk("mem_req_count", 128'(req_seen), 128'(req_exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual still running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int req0, b, sz, ln, bu;
        logic [31:0] ad;
        bit waited;
        rst_n = 0; s_ar_valid = 0; s_ar_addr = '0; s_ar_id = '0;
        s_ar_len = '0; s_ar_size = '0; s_ar_burst = '0; mem_rdata = '0;
        #3;
        chk("rst_ar_ready", s_ar_ready, 1);
        chk("rst_r_valid", s_r_valid, 0);
        chk("rst_r_last", s_r_last, 0);
        chk("rst_r_data", s_r_data, 0);
        chk("rst_r_resp_id", {s_r_resp, s_r_id}, 0);
        chk("rst_mem", {mem_req, mem_addr}, 0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;

        // pin the model against hand-derived word sequences
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("model_incr_w%0d", i), 128'(beat_addr(32'h40, 3, 3, 1, i) >> 3), 128'(w_incr[i]));
            chk($sformatf("model_wrap_w%0d", i), 128'(beat_addr(32'h58, 3, 3, 2, i) >> 3), 128'(w_wrap[i]));
        end

        // INCR line, ready high: latency and request timing
        rmode = 0;
        send_ar(32'h40, 4'h5, 3, 3, 1, 0);
        @(negedge clk);
        chk("mem_req_at_N+1", mem_req, 1);
        chk("mem_addr_at_N+1", mem_addr, 8);
        wait_done();
        chk("first_valid_latency", 128'(first_v_cyc - hs_cyc), 2);

        // WRAP critical-word-first, WRAP at boundary base
        send_ar(32'h58, 4'hA, 3, 3, 2, 0);
        wait_done();
        send_ar(32'h60, 4'h3, 3, 3, 2, 0);
        wait_done();

        // INCR len 7 with 1,0,0,1 ready
        rmode = 1; rpat = 0;
        send_ar(32'h200, 4'h7, 7, 3, 1, 0);
        wait_done();

        // reserved burst: no SRAM traffic at all
        rmode = 0;
        req0 = req_seen;
        send_ar(32'h80, 4'h9, 2, 3, 3, 0);
        wait_done();
        chk("reserved_no_req", 128'(req_seen - req0), 0);

        // top-of-memory crossing, bad WRAP len, FIXED, oversize, len 0, len 255
        send_ar(32'h7FE0, 4'h1, 7, 3, 1, 0);
        wait_done();
        send_ar(32'h100, 4'h2, 2, 3, 2, 0);
        wait_done();
        send_ar(32'h30, 4'h4, 3, 3, 0, 0);
        wait_done();
        send_ar(32'h40, 4'h6, 1, 4, 1, 0);
        wait_done();
        send_ar(32'h8, 4'hB, 0, 3, 1, 0);
        wait_done();
        rmode = 2;
        send_ar(32'h0, 4'hC, 255, 3, 1, 0);
        wait_done();

        // back-to-back, second held valid during the first
        send_ar(32'h400, 4'h1, 5, 3, 1, 0);
        send_ar(32'h500, 4'h2, 2, 3, 1, 1);
        wait_done();

        // reset after the second beat
        rmode = 0;
        n_beats = 0;
        send_ar(32'h100, 4'hD, 7, 3, 1, 0);
        for (int t = 0; t < 100 && n_beats < 2; t++) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("midrst_r_valid", s_r_valid, 0);
        chk("midrst_ar_ready", s_ar_ready, 1);
        chk("midrst_mem_req", mem_req, 0);
        exp_q.delete();
        req_seen = 0;
        req_exp  = 0;
        @(posedge clk);
        #2 rst_n = 1;
        @(posedge clk);
        #1;
        send_ar(32'h300, 4'hE, 3, 3, 1, 0);
        wait_done();

        // random bursts, some issued back-to-back
        waited = 1;
        for (int k = 0; k < 40; k++) begin
            rmode = $urandom_range(0, 2);
            rpat  = 0;
            b  = $urandom_range(0, 9);
            bu = (b == 0) ? 3 : (b < 3) ? 0 : (b < 6) ? 2 : 1;
            sz = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 7) : $urandom_range(0, 3);
            if (bu == 2 && $urandom_range(0, 4) != 0) ln = (2 << $urandom_range(0, 3)) - 1;
            else ln = $urandom_range(0, 31);
            ad = $urandom_range(0, 32'h8400);
            if (sz <= 3) ad = ad & ~((32'd1 << sz) - 32'd1);
            send_ar(ad, 4'($urandom), ln, sz, bu, !waited);
            waited = ($urandom_range(0, 2) != 0);
            if (waited) wait_done();
        end
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
